mips_run_ctrl: RTL and testbench

Run controller for the single-cycle MIPS core. It loads a program into instruction memory through the core's WE/W_Ins write path, then rewinds the core. After that it sequences execution: free run, single step, halt, and automatic stop at end of program. It sits between the board-level control inputs and the core, and gates the core's progress with a clock-enable.

---
 rtl/mips_run_ctrl.sv | 139 +++++++++++++
 tb/tb_mips_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: program load, rewind, run/step/halt sequencing.
// Optional breakpoint support (bp_en/bp_addr/bp_hit) is compiled in when BREAKPOINT_EN is defined.
module mips_run_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CW    = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_req,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run,
  input  logic          step,
  input  logic          halt,
  input  logic [31:0]   PC,
  output logic          cpu_ce,
  output logic          cpu_RST,
  output logic          cpu_WE,
  output logic [31:0]   cpu_W_Ins,
  output logic [2:0]    state,
  output logic [CW-1:0] words,
  output logic [31:0]   cycles,
`ifdef BREAKPOINT_EN
  input  logic          bp_en,
  input  logic [31:0]   bp_addr,
  output logic          bp_hit,
`endif
  output logic          end_hit
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD   = 3'd2,
    S_REWIND = 3'd3,
    S_READY  = 3'd4,
    S_RUN    = 3'd5,
    S_STEP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t      st;
  state_t      st_nxt;
  logic        rw_second;
  logic        accept;
  logic        at_end;
  logic        exec_st;
  logic        exec_ce;
  logic        bp_stop;
  logic [31:0] end_addr;

  assign state    = st;
  assign accept   = ld_valid && ld_ready;
  assign end_addr = 32'({words, 2'b00});
  assign at_end   = (PC == end_addr);
  assign exec_st  = (st == S_RUN) || (st == S_STEP);

`ifdef BREAKPOINT_EN
  logic bp_skip;
  // End of program takes precedence over a breakpoint on the same address
  assign bp_stop = (st == S_RUN) && bp_en && (PC == bp_addr) && !bp_skip && !at_end;
`else
  assign bp_stop = 1'b0;
`endif

  // PC changes every executed cycle, so the execute enable must follow PC combinationally
  assign exec_ce = exec_st && !at_end && !bp_stop;
  assign cpu_ce  = cpu_WE || exec_ce;

  // Next-state decode
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:   if (load_req) st_nxt = S_CLR;
      S_CLR:    st_nxt = S_LOAD;
      S_LOAD:   if (accept && (ld_last || (words == CW'(DEPTH - 1)))) st_nxt = S_REWIND;
      S_REWIND: if (rw_second) st_nxt = S_READY;
      S_READY, S_HALT: begin
        if (load_req)  st_nxt = S_CLR;
        else if (halt) st_nxt = st;
        else if (run)  st_nxt = S_RUN;
        else if (step) st_nxt = S_STEP;
      end
      S_RUN:    if (halt || at_end || bp_stop) st_nxt = S_HALT;
      S_STEP:   st_nxt = S_HALT;
      default:  st_nxt = S_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= S_IDLE;
      rw_second <= 1'b0;
      ld_ready  <= 1'b0;
      cpu_RST   <= 1'b0;
      cpu_WE    <= 1'b0;
      cpu_W_Ins <= 32'd0;
      words     <= '0;
      cycles    <= 32'd0;
      end_hit   <= 1'b0;
    end else begin
      st        <= st_nxt;
      rw_second <= (st == S_REWIND) && !rw_second;
      ld_ready  <= (st_nxt == S_LOAD);
      cpu_RST   <= !((st_nxt == S_IDLE) || (st_nxt == S_CLR) || (st_nxt == S_REWIND));
      cpu_WE    <= accept;
      if (accept) cpu_W_Ins <= ld_data;

      if (st_nxt == S_CLR) words <= '0;
      else if (accept)     words <= words + CW'(1);

      if (st == S_REWIND)                  cycles <= 32'd0;
      else if (exec_ce && (cycles != '1)) cycles <= cycles + 32'd1;

      if (st_nxt == S_CLR)         end_hit <= 1'b0;
      else if (exec_st && at_end) end_hit <= 1'b1;
    end
  end

`ifdef BREAKPOINT_EN
  // A run resumed from HALT steps past the breakpoint it stopped on
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bp_skip <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      bp_skip <= (st == S_HALT) && (st_nxt == S_RUN);
      if ((st_nxt != st) && ((st_nxt == S_RUN) || (st_nxt == S_STEP) || (st_nxt == S_CLR)))
        bp_hit <= 1'b0;
      else if (bp_stop)
        bp_hit <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a PC-only core model, a program-level reference model,
// and a monitor that scores write pulses and HALT entries against queued expectations.
module tb_mips_run_ctrl;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned CW    = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          load_req = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = 32'd0;
  logic          ld_last = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          halt = 1'b0;
  logic [31:0]   pc;
  logic          ld_ready, cpu_ce, cpu_RST, cpu_WE, end_hit;
  logic [31:0]   cpu_W_Ins, cycles;
  logic [2:0]    state;
  logic [CW-1:0] words;
`ifdef BREAKPOINT_EN
  logic          bp_en = 1'b0;
  logic [31:0]   bp_addr = 32'd0;
  logic          bp_hit;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wexp_t;
  typedef struct { int exec; logic [31:0] pc; bit end_hit; bit bp_hit; logic [31:0] cycles; } hrec_t;
  wexp_t wq[$];
  hrec_t hq[$];

  // Reference model: program length, word-index PC, counters, flags
  int          m_n = 0, m_p = 0, m_cyc = 0;
  bit          m_end = 0, m_bph = 0, m_inhalt = 0, m_bp_on = 0;
  logic [31:0] m_bp_a = 32'd0;
  logic [31:0] tv [3];

  mips_run_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .load_req(load_req), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .run(run), .step(step), .halt(halt), .PC(pc),
    .cpu_ce(cpu_ce), .cpu_RST(cpu_RST), .cpu_WE(cpu_WE), .cpu_W_Ins(cpu_W_Ins),
    .state(state), .words(words), .cycles(cycles),
`ifdef BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .end_hit(end_hit)
  );

  always #5 CLK = ~CLK;

  // Minimal core: synchronous reset of PC, advance by one word on enabled edges
  always_ff @(posedge CLK) begin
    if (!cpu_RST)    pc <= 32'd0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: scores write pulses, HALT entries and enable legality on every falling edge
  initial begin
    int    ce_cnt;
    logic [2:0] prev_st;
    wexp_t w;
    hrec_t r;
    bit    legal;
    ce_cnt  = 0;
    prev_st = 3'd0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        ce_cnt  = 0;
        prev_st = 3'd0;
      end else begin
        legal = cpu_WE ? ((state == 3'd2) || (state == 3'd3))
                       : (!cpu_ce || (state == 3'd5) || (state == 3'd6));
        chk("ce_we_legal", 32'(legal), 32'd1);
        if (cpu_ce && !cpu_WE) ce_cnt++;
        if (cpu_WE) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got %0h expected none", cpu_W_Ins);
          end else begin
            w = wq.pop_front();
            chk("wr_data", cpu_W_Ins, w.d);
            chk("wr_addr", pc, w.a);
          end
        end
        if ((state == 3'd7) && (prev_st != 3'd7)) begin
          if (hq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_halt: got HALT entry expected none at %0t", $time);
          end else begin
            r = hq.pop_front();
            chk("exec_ce_count", 32'(ce_cnt), 32'(r.exec));
            chk("halt_pc", pc, r.pc);
            chk("halt_end_hit", 32'(end_hit), 32'(r.end_hit));
            chk("halt_cycles", cycles, r.cycles);
`ifdef BREAKPOINT_EN
            chk("halt_bp_hit", 32'(bp_hit), 32'(r.bp_hit));
`endif
          end
          ce_cnt = 0;
        end
        prev_st = state;
      end
    end
  end

  task automatic do_load(input int n, input bit use_last, input bit issue_req, input bit use_tv);
    int w;
    logic [31:0] d;
    if (issue_req) begin
      load_req = 1'b1; tick(); load_req = 1'b0;
    end
    w = 0;
    while (!ld_ready && (w < 8)) begin tick(); w++; end
    chk("ld_ready_up", 32'(ld_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin ld_valid = 1'b0; tick(); end
      d = use_tv ? tv[i] : $urandom();
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = use_last && (i == n - 1);
      chk("ld_ready_hold", 32'(ld_ready), 32'd1);
      wq.push_back('{a: 32'(i * 4), d: d});
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("rewind1_state", 32'(state), 32'd3);
    chk("rewind_cpu_rst", 32'(cpu_RST), 32'd0);
    chk("ld_ready_drop", 32'(ld_ready), 32'd0);
    tick();
    chk("rewind2_state", 32'(state), 32'd3);
    tick();
    chk("ready_state", 32'(state), 32'd4);
    chk("ready_cpu_rst", 32'(cpu_RST), 32'd1);
    chk("words", 32'(words), 32'(n));
    chk("ready_pc", pc, 32'd0);
    chk("cycles_clear", cycles, 32'd0);
    chk("end_hit_clear", 32'(end_hit), 32'd0);
`ifdef BREAKPOINT_EN
    chk("bp_hit_clear", 32'(bp_hit), 32'd0);
`endif
    m_n = n; m_p = 0; m_cyc = 0; m_end = 0; m_bph = 0; m_inhalt = 0;
  endtask

  // Issue run or step; optionally pulse halt (and load_req) in RUN cycle halt_at
  task automatic do_exec(input bit is_step, input int halt_at, input bit with_load);
    int q, ex, w;
    bit e, b;
    q = m_p; ex = 0; e = m_end; b = 0;
    if (is_step) begin
      if (q == m_n) e = 1;
      else begin ex = 1; q++; end
    end else begin
      for (int c = 0; c < 256; c++) begin
        if (q == m_n) begin e = 1; break; end
        if (m_bp_on && (32'(q * 4) == m_bp_a) && !(m_inhalt && (c == 0))) begin b = 1; break; end
        ex++; q++;
        if (c == halt_at) break;
      end
    end
    m_p = q; m_cyc += ex; m_end = e; m_bph = b; m_inhalt = 1;
    hq.push_back('{exec: ex, pc: 32'(q * 4), end_hit: e, bp_hit: b, cycles: 32'(m_cyc)});
    if (is_step) step = 1'b1; else run = 1'b1;
    tick();
    step = 1'b0; run = 1'b0;
    if (halt_at >= 0) begin
      repeat (halt_at) tick();
      halt = 1'b1; load_req = with_load;
      tick();
      halt = 1'b0; load_req = 1'b0;
    end
    w = 0;
    while ((hq.size() != 0) && (w < 300)) begin tick(); w++; end
    if (hq.size() != 0) begin
      checks++; errors++;
      $display("FAIL halt_timeout: got no HALT entry expected one within 300 cycles");
      hq.delete();
    end
    tick();
  endtask

`ifdef BREAKPOINT_EN
  task automatic set_bp(input bit en, input logic [31:0] a);
    bp_en = en; bp_addr = a; m_bp_on = en; m_bp_a = a;
  endtask
`endif

  initial begin
    int n, k;
    tv[0] = 32'h2001_0005;
    tv[1] = 32'h2002_0003;
    tv[2] = 32'h0022_1820;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_words", 32'(words), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_end_hit", 32'(end_hit), 32'd0);
    chk("rst_cpu_we", 32'(cpu_WE), 32'd0);
    chk("rst_cpu_w_ins", cpu_W_Ins, 32'd0);
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_RST), 32'd0);
`ifdef BREAKPOINT_EN
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
`endif
    RST = 1'b1;
    tick(); tick();
    run = 1'b1; tick(); run = 1'b0; tick();
    chk("idle_ignores_run", 32'(state), 32'd0);

    // Three-word program, then free run to end
    do_load(3, 1'b1, 1'b1, 1'b1);
    do_exec(1'b0, -1, 1'b0);

    // Two steps then run to end
    do_load(4, 1'b1, 1'b1, 1'b0);
    do_exec(1'b1, -1, 1'b0);
    do_exec(1'b1, -1, 1'b0);
    do_exec(1'b0, -1, 1'b0);

    // halt outranks run in HALT; then run and step at end of program
    halt = 1'b1; run = 1'b1; tick(); halt = 1'b0; run = 1'b0;
    chk("halt_over_run", 32'(state), 32'd7);
    tick();
    chk("halt_stays", 32'(state), 32'd7);
    do_exec(1'b0, -1, 1'b0);
    do_exec(1'b1, -1, 1'b0);

    // Full-depth load without ld_last
    do_load(64, 1'b0, 1'b1, 1'b0);
    do_exec(1'b0, -1, 1'b0);

    // halt in READY, halt+load_req in RUN, load_req in HALT
    do_load(6, 1'b1, 1'b1, 1'b0);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("ready_halt_stays", 32'(state), 32'd4);
    do_exec(1'b0, 2, 1'b1);
    chk("run_ignores_load", 32'(state), 32'd7);
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("halt_load_clr", 32'(state), 32'd1);
    chk("halt_load_words", 32'(words), 32'd0);
    chk("halt_load_end_hit", 32'(end_hit), 32'd0);
    do_load(5, 1'b1, 1'b0, 1'b0);
    do_exec(1'b0, -1, 1'b0);

`ifdef BREAKPOINT_EN
    // Breakpoint at 0x08, then resume past it
    do_load(4, 1'b1, 1'b1, 1'b0);
    set_bp(1'b1, 32'h8);
    do_exec(1'b0, -1, 1'b0);
    do_exec(1'b0, -1, 1'b0);
    set_bp(1'b0, 32'h0);
`endif

    // Randomized programs and command sequences
    repeat (6) begin
      n = $urandom_range(1, 12);
      do_load(n, 1'b1, 1'b1, 1'b0);
      repeat (4) begin
`ifdef BREAKPOINT_EN
        set_bp(1'($urandom_range(0, 1)), 32'($urandom_range(0, n) * 4));
`endif
        k = $urandom_range(0, 2);
        if (k == 0)      do_exec(1'b1, -1, 1'b0);
        else if (k == 1) do_exec(1'b0, -1, 1'b0);
        else             do_exec(1'b0, $urandom_range(0, 4), 1'b0);
      end
    end
`ifdef BREAKPOINT_EN
    set_bp(1'b0, 32'h0);
`endif

    // Asynchronous reset in the middle of a run
    do_load(10, 1'b1, 1'b1, 1'b0);
    run = 1'b1; tick(); run = 1'b0;
    repeat (3) tick();
    #2 RST = 1'b0;
    #1;
    chk("midrun_rst_state", 32'(state), 32'd0);
    chk("midrun_rst_ce", 32'(cpu_ce), 32'd0);
    chk("midrun_rst_cpu_rst", 32'(cpu_RST), 32'd0);
    chk("midrun_rst_words", 32'(words), 32'd0);
    chk("midrun_rst_cycles", cycles, 32'd0);
    tick();
    RST = 1'b1;
    tick();
    do_load(2, 1'b1, 1'b1, 1'b0);
    do_exec(1'b0, -1, 1'b0);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("hq_drained", 32'(hq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
